// File: rtl/cq_viola_cpu_rstseq.sv
// ---------------------------------------------------------------------------
// cq_viola_cpu_rstseq
//
// Reset sequencer for the Nios II core in the cq_viola system. Host reset
// requests (a level from the reset-control PIO) and software reset pulses are
// turned into an Avalon reset handshake on the CPU:
//   1. raise resetrequest,
//   2. wait for resettaken, or give up after TAKEN_TIMEOUT cycles,
//   3. hold the peripheral/CPU reset domain in reset for HOLD_CYCLES cycles,
//      extended for as long as the host keeps its request high,
//   4. release for one cycle and go back to RUN.
// After system reset the block stays in BOOT for STARTUP_CYCLES cycles, and
// longer if the host is holding reset.
//
// Ports (all synchronous to core_clk):
//   core_clk          in   system clock, rising edge
//   reset             in   synchronous reset, active-high
//   host_req          in   host reset request level (reset_control_out_port)
//   sw_req            in   single-cycle software reset request pulse
//   cpu_resettaken    in   nios2_reset_resettaken
//   cpu_resetrequest  out  nios2_reset_resetrequest
//   core_reset        out  active-high reset for peripherals and CPU domain
//   cpu_running       out  high only while in RUN (reset_control_in_port)
//   timeout_flag      out  sticky, set when resettaken never arrived
//   reset_count       out  number of sequenced resets, saturates at 255
// ---------------------------------------------------------------------------
module cq_viola_cpu_rstseq #(
    parameter int STARTUP_CYCLES = 8,
    parameter int HOLD_CYCLES    = 16,
    parameter int TAKEN_TIMEOUT  = 1024
) (
    input  logic       core_clk,
    input  logic       reset,
    input  logic       host_req,
    input  logic       sw_req,
    input  logic       cpu_resettaken,
    output logic       cpu_resetrequest,
    output logic       core_reset,
    output logic       cpu_running,
    output logic       timeout_flag,
    output logic [7:0] reset_count
);

    // The shared down-counter only ever holds a load value minus one, so it
    // needs enough bits for the largest load minus one.
    localparam int MAX_LOAD_0 = (STARTUP_CYCLES > HOLD_CYCLES) ? STARTUP_CYCLES : HOLD_CYCLES;
    localparam int MAX_LOAD   = (MAX_LOAD_0 > TAKEN_TIMEOUT) ? MAX_LOAD_0 : TAKEN_TIMEOUT;
    localparam int CW         = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;

    localparam logic [CW-1:0] STARTUP_LOAD = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TAKEN_LOAD   = CW'(TAKEN_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_REQ     = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic            hq_d_r;

    logic            cnt_zero_s;
    logic            trigger_s;
    logic [7:0]      count_next_s;

    // Decode helpers: counter-at-zero, RUN trigger, saturating reset counter.
    always_comb begin
        cnt_zero_s   = (cnt_r == CNT_ZERO);
        trigger_s    = sw_req | (host_req & ~hq_d_r);
        if (reset_count == 8'd255) begin
            count_next_s = reset_count;
        end else begin
            count_next_s = reset_count + 8'd1;
        end
    end

    // Sequencer state machine; every output is updated together with the
    // state transition that implies it, so outputs are registered and track
    // the state one-to-one.
    always_ff @(posedge core_clk) begin
        // host_req edge register runs in every state, so a level held across
        // a sequence does not look like a new edge afterwards.
        hq_d_r <= host_req;

        if (reset) begin
            state_r          <= ST_BOOT;
            cnt_r            <= STARTUP_LOAD;
            hq_d_r           <= 1'b0;
            cpu_resetrequest <= 1'b0;
            core_reset       <= 1'b1;
            cpu_running      <= 1'b0;
            timeout_flag     <= 1'b0;
            reset_count      <= 8'd0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                    if (cnt_zero_s && !host_req) begin
                        state_r     <= ST_RUN;
                        core_reset  <= 1'b0;
                        cpu_running <= 1'b1;
                    end
                end

                ST_RUN: begin
                    // A simultaneous sw_req and host edge is one trigger.
                    if (trigger_s) begin
                        state_r          <= ST_REQ;
                        cnt_r            <= TAKEN_LOAD;
                        reset_count      <= count_next_s;
                        cpu_running      <= 1'b0;
                        cpu_resetrequest <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (cpu_resettaken) begin
                        state_r    <= ST_HOLD;
                        cnt_r      <= HOLD_LOAD;
                        core_reset <= 1'b1;
                    end else if (cnt_zero_s) begin
                        // The CPU never acknowledged; reset it anyway.
                        state_r      <= ST_HOLD;
                        cnt_r        <= HOLD_LOAD;
                        core_reset   <= 1'b1;
                        timeout_flag <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_HOLD: begin
                    if (!cnt_zero_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                    // A high host_req stretches the hold window.
                    if (cnt_zero_s && !host_req) begin
                        state_r          <= ST_RELEASE;
                        cpu_resetrequest <= 1'b0;
                        core_reset       <= 1'b0;
                    end
                end

                ST_RELEASE: begin
                    state_r     <= ST_RUN;
                    cpu_running <= 1'b1;
                end

                default: begin
                    // Unreachable encodings recover through BOOT.
                    state_r          <= ST_BOOT;
                    cnt_r            <= STARTUP_LOAD;
                    cpu_resetrequest <= 1'b0;
                    core_reset       <= 1'b1;
                    cpu_running      <= 1'b0;
                end
            endcase
        end
    end

endmodule
